// File: rtl/pi_code_ctrl.sv
// pi_code_ctrl: bang-bang CDR phase-interpolator code sequencer.
//
// Early/late votes from the bang-bang phase detector are integrated in a
// signed accumulator. Reaching +/-VOTE_TH steps the 11-bit PI code, which
// wraps modulo 2048 so the phase stays continuous. Steps are coarse in ACQ and
// fine in TRACK. A counted number of direction reversals promotes ACQ to TRACK.
// A long run of same-direction steps in TRACK drops back to ACQ. FREEZE parks
// the controller in HOLD, and HOLD remembers the state it came from.
//
// Optional feature macro: PI_CTRL_EXT_LOAD_EN
//   When it is defined, the LOAD / LOAD_CODE ports are added. They force the
//   code to an external value and restart acquisition. Without the macro the
//   code changes only through votes or reset.
module pi_code_ctrl #(
  parameter int INIT_CODE  = 0,
  parameter int VOTE_TH    = 8,
  parameter int ACQ_STEP   = 16,
  parameter int TRK_STEP   = 1,
  parameter int REV_LOCK   = 4,
  parameter int RUN_UNLOCK = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        VOTE_VLD,
  input  logic        UP,
  input  logic        DN,
  input  logic        FREEZE,
  output logic [10:0] Code,
  output logic        CODE_UPD,
  output logic        LOCK
`ifdef PI_CTRL_EXT_LOAD_EN
  ,
  input  logic        LOAD,
  input  logic [10:0] LOAD_CODE
`endif
);

  typedef enum logic [1:0] {
    ST_ACQ   = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [10:0]        INIT_CODE_C  = 11'(INIT_CODE);
  localparam logic [10:0]        ACQ_STEP_C   = 11'(ACQ_STEP);
  localparam logic [10:0]        TRK_STEP_C   = 11'(TRK_STEP);
  localparam logic signed [7:0]  TH_POS       = 8'(VOTE_TH);
  localparam logic signed [7:0]  TH_NEG       = -TH_POS;
  localparam logic [7:0]         REV_LOCK_C   = 8'(REV_LOCK);
  localparam logic [7:0]         RUN_UNLOCK_C = 8'(RUN_UNLOCK);

  // External load path; without the feature it is tied inactive.
  logic        load_w;
  logic [10:0] load_code_w;
`ifdef PI_CTRL_EXT_LOAD_EN
  assign load_w      = LOAD;
  assign load_code_w = LOAD_CODE;
`else
  assign load_w      = 1'b0;
  assign load_code_w = INIT_CODE_C;
`endif

  // State registers and their next-state values.
  state_t           state_q, state_d;
  state_t           prior_q, prior_d;     // state to resume after HOLD
  logic signed [7:0] acc_q, acc_d;
  logic [10:0]      code_q, code_d;
  logic             upd_q, upd_d;
  logic             lock_q, lock_d;
  logic             dir_vld_q, dir_vld_d; // last_dir is meaningful
  logic             dir_q, dir_d;         // last step direction, 1 = up
  logic [7:0]       rev_q, rev_d;
  logic [7:0]       run_q, run_d;

  // Combinational helpers.
  logic signed [7:0] acc_sum;
  logic              step_up;
  logic              step_dn;
  logic [10:0]       step_sz;
  logic [7:0]        rev_inc;
  logic [7:0]        run_inc;

  // Vote integration and step detection (only meaningful outside HOLD).
  always_comb begin
    acc_sum = acc_q;
    if (VOTE_VLD && UP && !DN) begin
      acc_sum = acc_q + 8'sd1;
    end else if (VOTE_VLD && DN && !UP) begin
      acc_sum = acc_q - 8'sd1;
    end
    step_up = (acc_sum == TH_POS);
    step_dn = (acc_sum == TH_NEG);
    step_sz = (state_q == ST_TRACK) ? TRK_STEP_C : ACQ_STEP_C;
    rev_inc = rev_q + 8'd1;
    // A run continues only when the previous step is known and in the same
    // direction; the first step after entering TRACK (run_q == 0) restarts at 1.
    if ((run_q != 8'd0) && dir_vld_q && (dir_q == step_up)) begin
      run_inc = run_q + 8'd1;
    end else begin
      run_inc = 8'd1;
    end
  end

  // Next-state logic: the load path comes first, then FREEZE/HOLD, then vote steps.
  always_comb begin
    state_d   = state_q;
    prior_d   = prior_q;
    acc_d     = acc_q;
    code_d    = code_q;
    upd_d     = 1'b0;
    dir_vld_d = dir_vld_q;
    dir_d     = dir_q;
    rev_d     = rev_q;
    run_d     = run_q;

    if (load_w) begin
      state_d   = ST_ACQ;
      prior_d   = ST_ACQ;
      acc_d     = '0;
      code_d    = load_code_w;
      upd_d     = 1'b1;
      dir_vld_d = 1'b0;
      rev_d     = '0;
      run_d     = '0;
    end else if (FREEZE) begin
      // A threshold vote landing together with FREEZE is discarded.
      state_d = ST_HOLD;
      if (state_q != ST_HOLD) begin
        prior_d = state_q;
      end
      acc_d = '0;
    end else if (state_q == ST_HOLD) begin
      // The release cycle itself ignores votes; integration restarts from zero.
      state_d   = prior_q;
      acc_d     = '0;
      dir_vld_d = 1'b0;
    end else begin
      acc_d = acc_sum;
      if (step_up || step_dn) begin
        acc_d     = '0;
        upd_d     = 1'b1;
        code_d    = step_up ? (code_q + step_sz) : (code_q - step_sz);
        dir_d     = step_up;
        dir_vld_d = 1'b1;
        if (state_q == ST_ACQ) begin
          if (dir_vld_q && (dir_q != step_up)) begin
            if (rev_inc == REV_LOCK_C) begin
              state_d = ST_TRACK;
              rev_d   = '0;
              run_d   = '0;
            end else begin
              rev_d = rev_inc;
            end
          end
        end else begin
          if (run_inc == RUN_UNLOCK_C) begin
            // A long one-sided run means the loop lost lock; reacquire coarsely.
            state_d   = ST_ACQ;
            rev_d     = '0;
            run_d     = '0;
            dir_vld_d = 1'b0;
          end else begin
            run_d = run_inc;
          end
        end
      end
    end

    lock_d = (state_d == ST_TRACK) ||
             ((state_d == ST_HOLD) && (prior_d == ST_TRACK));
  end

  // Register all state and outputs; synchronous reset has priority over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_ACQ;
      prior_q   <= ST_ACQ;
      acc_q     <= '0;
      code_q    <= INIT_CODE_C;
      upd_q     <= 1'b0;
      lock_q    <= 1'b0;
      dir_vld_q <= 1'b0;
      dir_q     <= 1'b0;
      rev_q     <= '0;
      run_q     <= '0;
    end else begin
      state_q   <= state_d;
      prior_q   <= prior_d;
      acc_q     <= acc_d;
      code_q    <= code_d;
      upd_q     <= upd_d;
      lock_q    <= lock_d;
      dir_vld_q <= dir_vld_d;
      dir_q     <= dir_d;
      rev_q     <= rev_d;
      run_q     <= run_d;
    end
  end

  assign Code     = code_q;
  assign CODE_UPD = upd_q;
  assign LOCK     = lock_q;

endmodule

// File: tb/tb_pi_code_ctrl.sv
// Directed testbench for pi_code_ctrl. Instance "a" uses INIT_CODE=0 and
// instance "b" uses INIT_CODE=2040; the two share all stimulus.
module tb_pi_code_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        VOTE_VLD;
  logic        UP;
  logic        DN;
  logic        FREEZE;
  logic [10:0] code_a, code_b;
  logic        upd_a, upd_b;
  logic        lock_a, lock_b;
`ifdef PI_CTRL_EXT_LOAD_EN
  logic        LOAD;
  logic [10:0] LOAD_CODE;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pi_code_ctrl #(.INIT_CODE(0)) dut_a (
    .CLK(CLK), .RST(RST), .VOTE_VLD(VOTE_VLD), .UP(UP), .DN(DN), .FREEZE(FREEZE),
    .Code(code_a), .CODE_UPD(upd_a), .LOCK(lock_a)
`ifdef PI_CTRL_EXT_LOAD_EN
    , .LOAD(LOAD), .LOAD_CODE(LOAD_CODE)
`endif
  );

  pi_code_ctrl #(.INIT_CODE(2040)) dut_b (
    .CLK(CLK), .RST(RST), .VOTE_VLD(VOTE_VLD), .UP(UP), .DN(DN), .FREEZE(FREEZE),
    .Code(code_b), .CODE_UPD(upd_b), .LOCK(lock_b)
`ifdef PI_CTRL_EXT_LOAD_EN
    , .LOAD(LOAD), .LOAD_CODE(LOAD_CODE)
`endif
  );

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic u, input logic d, input logic f);
    VOTE_VLD = v; UP = u; DN = d; FREEZE = f;
    @(posedge CLK);
    #1;
  endtask

  task automatic votes(input logic up_dir, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, up_dir, !up_dir, 1'b0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
  endtask

  // Five alternating bursts: UP, DN, UP, DN, UP. The reversals are counted
  // 1..4 and take the controller to TRACK.
  task automatic acquire();
    for (int b = 0; b < 5; b++) votes((b % 2) == 0, 8);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (code_a !== 11'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", code_a); end
    checks++; if (code_b !== 11'd2040) begin errors++; $display("FAIL reset_code_b got=%0d exp=2040", code_b); end
    checks++; if (upd_a !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b exp=0", upd_a); end
    checks++; if (lock_a !== 1'b0) begin errors++; $display("FAIL reset_lock got=%b exp=0", lock_a); end
    $display("test_reset done code=%0d", code_a);
  endtask

  task automatic test_step_up();
    do_reset();
    votes(1'b1, 7);
    checks++; if (code_a !== 11'd0) begin errors++; $display("FAIL pre_step_code got=%0d exp=0", code_a); end
    checks++; if (upd_a !== 1'b0) begin errors++; $display("FAIL pre_step_upd got=%b exp=0", upd_a); end
    votes(1'b1, 1);
    checks++; if (code_a !== 11'd16) begin errors++; $display("FAIL step_up_code got=%0d exp=16", code_a); end
    checks++; if (upd_a !== 1'b1) begin errors++; $display("FAIL step_up_upd got=%b exp=1", upd_a); end
    checks++; if (lock_a !== 1'b0) begin errors++; $display("FAIL step_up_lock got=%b exp=0", lock_a); end
    checks++; if (code_b !== 11'd8) begin errors++; $display("FAIL wrap_up_code got=%0d exp=8", code_b); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (upd_a !== 1'b0) begin errors++; $display("FAIL upd_single_pulse got=%b exp=0", upd_a); end
    $display("test_step_up done code=%0d wrap=%0d", code_a, code_b);
  endtask

  task automatic test_wrap_down();
    do_reset();
    votes(1'b0, 8);
    checks++; if (code_a !== 11'd2032) begin errors++; $display("FAIL wrap_dn_code got=%0d exp=2032", code_a); end
    checks++; if (code_b !== 11'd2024) begin errors++; $display("FAIL dn_code_b got=%0d exp=2024", code_b); end
    checks++; if (upd_a !== 1'b1) begin errors++; $display("FAIL wrap_dn_upd got=%b exp=1", upd_a); end
    $display("test_wrap_down done code=%0d", code_a);
  endtask

  task automatic test_acquire_unlock();
    logic [10:0] exp_code [5];
    logic        exp_lock [5];
    exp_code = '{11'd16, 11'd0, 11'd16, 11'd0, 11'd16};
    exp_lock = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int b = 0; b < 5; b++) begin
      votes((b % 2) == 0, 8);
      checks++; if (code_a !== exp_code[b]) begin errors++; $display("FAIL acq_code burst=%0d got=%0d exp=%0d", b, code_a, exp_code[b]); end
      checks++; if (lock_a !== exp_lock[b]) begin errors++; $display("FAIL acq_lock burst=%0d got=%b exp=%b", b, lock_a, exp_lock[b]); end
    end
    // First TRACK step is fine.
    votes(1'b0, 8);
    checks++; if (code_a !== 11'd15) begin errors++; $display("FAIL trk_fine_code got=%0d exp=15", code_a); end
    checks++; if (lock_a !== 1'b1) begin errors++; $display("FAIL trk_fine_lock got=%b exp=1", lock_a); end
    // Sixteen same-direction steps; the 16th still uses the fine step and drops lock.
    for (int b = 0; b < 16; b++) begin
      votes(1'b1, 8);
      checks++; if (code_a !== 11'(16 + b)) begin errors++; $display("FAIL run_code burst=%0d got=%0d exp=%0d", b, code_a, 16 + b); end
      checks++; if (lock_a !== (b < 15)) begin errors++; $display("FAIL run_lock burst=%0d got=%b exp=%b", b, lock_a, (b < 15)); end
    end
    votes(1'b1, 8);
    checks++; if (code_a !== 11'd47) begin errors++; $display("FAIL reacq_code got=%0d exp=47", code_a); end
    checks++; if (lock_a !== 1'b0) begin errors++; $display("FAIL reacq_lock got=%b exp=0", lock_a); end
    $display("test_acquire_unlock done code=%0d lock=%b", code_a, lock_a);
  endtask

  task automatic test_mixed();
    do_reset();
    votes(1'b1, 7);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (code_a !== 11'd0) begin errors++; $display("FAIL mixed_hold_code got=%0d exp=0", code_a); end
    checks++; if (upd_a !== 1'b0) begin errors++; $display("FAIL mixed_hold_upd got=%b exp=0", upd_a); end
    votes(1'b1, 1);
    checks++; if (code_a !== 11'd16) begin errors++; $display("FAIL mixed_step_code got=%0d exp=16", code_a); end
    votes(1'b0, 7);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (code_a !== 11'd16) begin errors++; $display("FAIL mixed_dn_hold got=%0d exp=16", code_a); end
    votes(1'b0, 1);
    checks++; if (code_a !== 11'd0) begin errors++; $display("FAIL mixed_dn_step got=%0d exp=0", code_a); end
    $display("test_mixed done code=%0d", code_a);
  endtask

  task automatic test_freeze();
    do_reset();
    acquire();
    votes(1'b1, 4);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      checks++; if (code_a !== 11'd16 || upd_a !== 1'b0) begin errors++; $display("FAIL freeze_code i=%0d got=%0d upd=%b exp=16 upd=0", i, code_a, upd_a); end
    end
    checks++; if (lock_a !== 1'b1) begin errors++; $display("FAIL freeze_lock got=%b exp=1", lock_a); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (lock_a !== 1'b1) begin errors++; $display("FAIL release_lock got=%b exp=1", lock_a); end
    votes(1'b1, 7);
    checks++; if (code_a !== 11'd16) begin errors++; $display("FAIL release_acc_code got=%0d exp=16", code_a); end
    votes(1'b1, 1);
    checks++; if (code_a !== 11'd17) begin errors++; $display("FAIL release_step_code got=%0d exp=17", code_a); end
    checks++; if (upd_a !== 1'b1) begin errors++; $display("FAIL release_step_upd got=%b exp=1", upd_a); end
    // Threshold vote coinciding with FREEZE rising: no step and acc cleared.
    votes(1'b1, 7);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (code_a !== 11'd17 || upd_a !== 1'b0) begin errors++; $display("FAIL freeze_edge_code got=%0d upd=%b exp=17 upd=0", code_a, upd_a); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    votes(1'b1, 1);
    checks++; if (code_a !== 11'd17) begin errors++; $display("FAIL freeze_edge_acc got=%0d exp=17", code_a); end
    votes(1'b1, 7);
    checks++; if (code_a !== 11'd18) begin errors++; $display("FAIL freeze_edge_step got=%0d exp=18", code_a); end
    $display("test_freeze done code=%0d lock=%b", code_a, lock_a);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    votes(1'b1, 8);
    votes(1'b1, 5);
    RST = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    RST = 1'b0;
    checks++; if (code_a !== 11'd0) begin errors++; $display("FAIL rst_mid_code got=%0d exp=0", code_a); end
    checks++; if (code_b !== 11'd2040) begin errors++; $display("FAIL rst_mid_code_b got=%0d exp=2040", code_b); end
    votes(1'b1, 7);
    checks++; if (code_a !== 11'd0) begin errors++; $display("FAIL rst_mid_acc got=%0d exp=0", code_a); end
    votes(1'b1, 1);
    checks++; if (code_a !== 11'd16) begin errors++; $display("FAIL rst_mid_step got=%0d exp=16", code_a); end
    $display("test_reset_mid_burst done code=%0d", code_a);
  endtask

`ifdef PI_CTRL_EXT_LOAD_EN
  task automatic test_load();
    do_reset();
    acquire();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    LOAD = 1'b1; LOAD_CODE = 11'h5A3;
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    LOAD = 1'b0;
    checks++; if (code_a !== 11'h5A3) begin errors++; $display("FAIL load_code got=%h exp=5a3", code_a); end
    checks++; if (lock_a !== 1'b0) begin errors++; $display("FAIL load_lock got=%b exp=0", lock_a); end
    checks++; if (upd_a !== 1'b1) begin errors++; $display("FAIL load_upd got=%b exp=1", upd_a); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    $display("test_load done code=%h", code_a);
  endtask
`endif

  initial begin
    RST = 1'b1; VOTE_VLD = 1'b0; UP = 1'b0; DN = 1'b0; FREEZE = 1'b0;
`ifdef PI_CTRL_EXT_LOAD_EN
    LOAD = 1'b0; LOAD_CODE = '0;
`endif
    test_reset();
    test_step_up();
    test_wrap_down();
    test_acquire_unlock();
    test_mixed();
    test_freeze();
    test_reset_mid_burst();
`ifdef PI_CTRL_EXT_LOAD_EN
    test_load();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
